// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and FSM state encodings. UART_PARITY_EN adds the PARITY state.
package mmio_uart_tx_pkg;

  localparam int REG_W = 32;

  localparam logic [2:0] UART_TXDATA_OFF = 3'd0;
  localparam logic [2:0] UART_STATUS_OFF = 3'd4;

  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_CNT_LSB   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

  // STATUS only has a 4-bit count field, so deep FIFOs report 15 when fuller.
  function automatic logic [3:0] satCount4(input logic [6:0] cnt);
    return (cnt > 7'd15) ? 4'hF : cnt[3:0];
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [7:0]               i_din,
  output logic [7:0]               o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count = r_wptr - r_rptr;
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS window on the data bus, byte FIFO,
// 8N1 serialiser. Define UART_PARITY_EN to insert an even parity bit before stop.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [3:0]       sel,
  input  logic [REG_W-1:0] data_i,
  output logic [REG_W-1:0] data_o,
  output logic             txd
);

  localparam int          FCW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LOAD = 16'(CLK_DIV - 1);

  logic           w_hit;
  logic           w_is_txdata;
  logic           w_is_status;
  logic           w_push_req;
  logic           w_status_wr;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [7:0]     w_dout;
  logic [FCW-1:0] w_count;
  logic           w_busy;
  logic           w_unused;

  tx_state_e   r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_txd;
  logic        r_ovf;

  assign w_hit       = ce && (addr[31:3] == BASE_ADDR[31:3]);
  assign w_is_txdata = (addr[2] == UART_TXDATA_OFF[2]);
  assign w_is_status = (addr[2] == UART_STATUS_OFF[2]);
  assign w_push_req  = w_hit && we && (sel != 4'd0) && w_is_txdata;
  assign w_status_wr = w_hit && we && w_is_status;
  assign w_pop       = (r_state == ST_IDLE) && !w_empty;
  assign w_busy      = (r_state != ST_IDLE);
  assign txd         = r_txd;
  assign w_unused    = ^{addr[1:0], data_i[REG_W-1:8]};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_din   (data_i[7:0]),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_status_wr) begin
      r_ovf <= 1'b0;
    end else if (w_push_req && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end
  end

  // r_shift holds the whole byte for the frame; r_bit selects the bit on the wire.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_shift <= w_dout;
            r_bit   <= '0;
            r_baud  <= BAUD_LOAD;
            r_txd   <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_baud == '0) begin
            r_baud  <= BAUD_LOAD;
            r_txd   <= r_shift[0];
            r_state <= ST_DATA;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        ST_DATA: begin
          if (r_baud == '0) begin
            r_baud <= BAUD_LOAD;
            r_bit  <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              r_txd   <= ^r_shift;
              r_state <= ST_PARITY;
`else
              r_txd   <= 1'b1;
              r_state <= ST_STOP;
`endif
            end else begin
              r_txd <= r_shift[r_bit + 3'd1];
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (r_baud == '0) begin
            r_baud  <= BAUD_LOAD;
            r_txd   <= 1'b1;
            r_state <= ST_STOP;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (r_baud == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    data_o = '0;
    if (w_hit && w_is_status) begin
      data_o[ST_CNT_LSB +: 4] = satCount4(7'(w_count));
      data_o[ST_OVF_BIT]      = r_ovf;
      data_o[ST_EMPTY_BIT]    = w_empty;
      data_o[ST_FULL_BIT]     = w_full;
      data_o[ST_BUSY_BIT]     = w_busy;
    end
  end

endmodule
